data_mem_access_unit: RTL and testbench

- Executes the data-memory side of decoded MIPS loads and stores (LW/LH/LB/SW/SH/SB). Consumes the MemRead/MemWrite/Load_size/Store_size control fields and the ALU-computed address.
- Performs word-aligned accesses to a single-port synchronous word RAM. Sub-word stores use read-modify-write, and loads are sign-extended.
- Sits between the EX/MEM stage and data memory, with a valid/ready request handshake and a one-cycle response pulse.

---
 rtl/data_mem_access_unit_pkg.sv | 35 +++
 rtl/data_mem_access_unit_byte_lane_merge.sv | 50 +++++
 rtl/data_mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_data_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_access_unit_pkg
// Description : Access-size and FSM state encodings for the data-memory unit.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_access_unit_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_LDFMT = 3'd2;
    localparam logic [2:0] ST_MERGE = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    // True when the access cannot be issued as one aligned word-RAM access.
    function automatic logic size_fault(input logic [1:0] size, input logic [1:0] offset);
        logic f;
        f = 1'b0;
        case (size)
            SIZE_WORD: f = (offset != 2'b00);
            SIZE_HALF: f = offset[0];
            SIZE_BYTE: f = 1'b0;
            default:   f = 1'b1;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_access_unit_byte_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_merge
// Description : Little-endian lane extraction (sign-extended) and lane merge.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_merge
    import data_mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [4:0] w_bit_base;
    logic [7:0] w_byte;

    assign w_bit_base = {offset, 3'b000};
    assign w_byte     = word[w_bit_base +: 8];

    always_comb begin
        load_value  = word;
        merged_word = data;
        case (size)
            SIZE_HALF: begin
                if (offset[1]) begin
                    load_value  = {{16{word[31]}}, word[31:16]};
                    merged_word = {data[15:0], word[15:0]};
                end else begin
                    load_value  = {{16{word[15]}}, word[15:0]};
                    merged_word = {word[31:16], data[15:0]};
                end
            end
            SIZE_BYTE: begin
                load_value                     = {{24{w_byte[7]}}, w_byte};
                merged_word                    = word;
                merged_word[w_bit_base +: 8]   = data[7:0];
            end
            default: begin
                load_value  = word;
                merged_word = data;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_access_unit
// Description : MIPS load/store engine over a single-port synchronous word RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Load_size,
    input  logic [1:0]        Store_size,
    input  logic [31:0]       Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              rsp_valid,
    output logic              misalign_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    import data_mem_access_unit_pkg::*;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_is_load;
    logic [1:0]        r_size;
    logic [1:0]        r_offset;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rsp_valid;
    logic              r_misalign;
    logic [31:0]       r_read_data;
    logic [31:0]       r_ram_wdata;

    logic              w_accept;
    logic [1:0]        w_size;
    logic              w_noop;
    logic              w_err;
    logic              w_word_store;
    logic [31:0]       w_load_value;
    logic [31:0]       w_merged;
    logic              w_unused_addr;

    assign w_accept     = req_valid & req_ready;
    assign w_size       = MemWrite ? Store_size : Load_size;
    assign w_noop       = ~MemRead & ~MemWrite;
    assign w_err        = (MemRead & MemWrite) |
                          (~w_noop & size_fault(w_size, Address[1:0]));
    assign w_word_store = MemWrite & ~MemRead & (w_size == SIZE_WORD);
    // Upper address bits are deliberately dropped so the address wraps.
    assign w_unused_addr = ^Address[31:ADDR_W+2];

    byte_lane_merge u_lane (
        .size        (r_size),
        .offset      (r_offset),
        .word        (ram_rdata),
        .data        (r_wdata),
        .load_value  (w_load_value),
        .merged_word (w_merged)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err || w_noop)   w_next = ST_RESP;
                    else if (MemRead)      w_next = ST_RD;
                    else if (w_word_store) w_next = ST_WR;
                    else                   w_next = ST_RD;
                end
            end
            ST_RD:    w_next = r_is_load ? ST_LDFMT : ST_MERGE;
            ST_LDFMT: w_next = ST_IDLE;
            ST_MERGE: w_next = ST_WR;
            ST_WR:    w_next = ST_IDLE;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE);
        ram_en    = (r_state == ST_RD) || (r_state == ST_WR);
        ram_we    = (r_state == ST_WR);
    end

    // Request capture and registered response/data path.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_is_load   <= 1'b0;
            r_size      <= SIZE_WORD;
            r_offset    <= 2'b00;
            r_wdata     <= 32'd0;
            r_addr      <= '0;
            r_rsp_valid <= 1'b0;
            r_misalign  <= 1'b0;
            r_read_data <= 32'd0;
            r_ram_wdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_misalign  <= 1'b0;
            if (w_accept) begin
                r_is_load   <= MemRead;
                r_size      <= w_size;
                r_offset    <= Address[1:0];
                r_wdata     <= WriteData;
                r_addr      <= Address[ADDR_W+1:2];
                r_rsp_valid <= w_err | w_noop;
                r_misalign  <= w_err;
                if (w_word_store && !w_err) begin
                    r_ram_wdata <= WriteData;
                end
            end
            case (r_state)
                ST_LDFMT: begin
                    r_read_data <= w_load_value;
                    r_rsp_valid <= 1'b1;
                end
                ST_MERGE: r_ram_wdata <= w_merged;
                ST_WR:    r_rsp_valid <= 1'b1;
                default:  ;
            endcase
        end
    end

    assign ReadData     = r_read_data;
    assign rsp_valid    = r_rsp_valid;
    assign misalign_err = r_misalign;
    assign ram_addr     = r_addr;
    assign ram_wdata    = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_access_unit
// Description : Scoreboard bench for data_mem_access_unit with a word-RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_access_unit;
    import data_mem_access_unit_pkg::*;

    localparam int ADDR_W = 10;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic [1:0]        Load_size = 2'b00;
    logic [1:0]        Store_size = 2'b00;
    logic [31:0]       Address = 32'd0;
    logic [31:0]       WriteData = 32'd0;
    logic              req_ready;
    logic [31:0]       ReadData;
    logic              rsp_valid;
    logic              misalign_err;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;

    data_mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .Load_size(Load_size),
        .Store_size(Store_size), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .rsp_valid(rsp_valid), .misalign_err(misalign_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 Clk = ~Clk;

    bit   [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [31:0] pl_data = 32'd0;

    always @(posedge Clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int cyc = 0;
    int acc_cnt = 0;
    int en_cnt = 0;
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (ram_en) en_cnt <= en_cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_rd = 32'd0;

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (!Rst) begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rsp_latency", cyc, e.due);
                    check("rsp_err", {31'd0, misalign_err}, {31'd0, e.err});
                    check("rsp_readdata", ReadData, e.rd);
                end
            end else if (misalign_err) begin
                check("err_without_rsp", {31'd0, misalign_err}, 32'd0);
            end
        end
    end

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge Clk);
        pl_en   = 1'b1;
        pl_addr = a[9:0];
        pl_data = d;
        @(negedge Clk);
        pl_en   = 1'b0;
    endtask

    // Called at a negedge; holds the request until accepted and queues the expectation.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] lsz,
                         input logic [1:0] ssz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic exp_err, input int lat,
                         input logic [31:0] ld_val);
        exp_t e;
        int   n;
        n = 0;
        MemRead = rd; MemWrite = wr; Load_size = lsz; Store_size = ssz;
        Address = addr; WriteData = wd; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
        if (rd && !wr && !exp_err) model_rd = ld_val;
        e.due = cyc + lat;
        e.err = exp_err;
        e.rd  = model_rd;
        q.push_back(e);
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        Address   = $urandom;
        WriteData = $urandom;
        Load_size = 2'($urandom);
        Store_size = 2'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge Clk);
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    task automatic run(input logic rd, input logic wr, input logic [1:0] lsz,
                       input logic [1:0] ssz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic exp_err, input int lat,
                       input logic [31:0] ld_val);
        @(negedge Clk);
        issue(rd, wr, lsz, ssz, addr, wd, exp_err, lat, ld_val);
        drain();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int en0;
        int acc0;
        repeat (3) @(negedge Clk);
        check("rst_readdata", ReadData, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        Rst = 1'b0;

        preload(4, 32'h8899AABB);
        preload(5, 32'h11223344);
        preload(12, 32'h0);

        run(1, 0, SIZE_WORD, SIZE_WORD, 32'h10, 0, 0, 3, 32'h8899AABB);
        run(1, 0, SIZE_BYTE, SIZE_WORD, 32'h11, 0, 0, 3, 32'hFFFFFFAA);
        run(1, 0, SIZE_HALF, SIZE_WORD, 32'h12, 0, 0, 3, 32'hFFFF8899);
        run(1, 0, SIZE_BYTE, SIZE_WORD, 32'h10, 0, 0, 3, 32'hFFFFFFBB);

        run(0, 1, SIZE_WORD, SIZE_BYTE, 32'h16, 32'h000000A5, 0, 4, 0);
        check("sb_mem5", mem[5], 32'h11A53344);
        run(0, 1, SIZE_WORD, SIZE_HALF, 32'h14, 32'h1234BEEF, 0, 4, 0);
        check("sh_mem5", mem[5], 32'h11A5BEEF);

        // Word store followed by a load issued in the response cycle.
        @(negedge Clk);
        issue(0, 1, SIZE_WORD, SIZE_WORD, 32'h20, 32'hDEADBEEF, 0, 2, 0);
        @(negedge Clk);
        check("sw_ram_en", {31'd0, ram_en}, 32'd1);
        check("sw_ram_we", {31'd0, ram_we}, 32'd1);
        check("sw_ram_wdata", ram_wdata, 32'hDEADBEEF);
        check("sw_ram_addr", {22'd0, ram_addr}, 32'd8);
        @(negedge Clk);
        check("b2b_ready", {31'd0, req_ready}, 32'd1);
        issue(1, 0, SIZE_WORD, SIZE_WORD, 32'h20, 0, 0, 3, 32'hDEADBEEF);
        drain();

        en0 = en_cnt;
        run(1, 0, SIZE_WORD, SIZE_WORD, 32'h22, 0, 1, 1, 0);
        run(1, 0, SIZE_HALF, SIZE_WORD, 32'h23, 0, 1, 1, 0);
        run(0, 1, SIZE_WORD, SIZE_RSVD, 32'h14, 32'h000000FF, 1, 1, 0);
        run(1, 1, SIZE_WORD, SIZE_WORD, 32'h20, 32'h0, 1, 1, 0);
        run(0, 0, SIZE_WORD, SIZE_WORD, 32'h20, 32'h0, 0, 1, 0);
        @(negedge Clk);
        check("err_no_ram_en", en_cnt, en0);
        check("err_mem8", mem[8], 32'hDEADBEEF);
        check("err_mem5", mem[5], 32'h11A5BEEF);

        // Request held valid while the address changes under it.
        @(negedge Clk);
        acc0 = acc_cnt;
        issue(1, 0, SIZE_WORD, SIZE_WORD, 32'h10, 0, 0, 3, 32'h8899AABB);
        req_valid = 1'b1;
        MemRead = 1'b1; MemWrite = 1'b0; Load_size = SIZE_WORD;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("hold_ram_addr", {22'd0, ram_addr}, 32'd4);
            Address = 32'h100 + 32'(i * 4);
        end
        req_valid = 1'b0;
        drain();
        check("hold_accepts", acc_cnt - acc0, 32'd1);

        // Reset during the MERGE cycle drops the sub-word store.
        @(negedge Clk);
        issue(0, 1, SIZE_WORD, SIZE_BYTE, 32'h30, 32'h000000FF, 0, 4, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        q.delete();
        @(negedge Clk);
        Rst = 1'b0;
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (6) @(negedge Clk);
        check("rst_mid_mem12", mem[12], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
